// File: rtl/clk_period_monitor.sv
// Half-period monitor for divider-generated slow clocks: reports lock, stall and error count.
// Optional macro CLK_MON_ERRCNT_EN enables the out-of-tolerance counter on o_errCnt.
module clk_period_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 20,
    parameter int EXP_HALF    = 50000,
    parameter int TOL         = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 200000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic             i_clr,
    input  logic             i_divClk,
    output logic [CNT_W-1:0] o_halfPeriod,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_stall,
    output logic [7:0]       o_errCnt
);

    // state   | meaning
    // IDLE    | monitor disabled, counter held at zero
    // ARM     | waiting for the first edge; counts only for the stall timeout
    // MEASURE | counting cycles between edges, each edge yields a measurement
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int                     RUN_W       = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]       CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic signed [CNT_W:0]  EXP_S       = (CNT_W + 1)'(EXP_HALF);
    localparam logic [CNT_W:0]         TOL_U       = (CNT_W + 1)'(TOL);
    localparam logic [RUN_W-1:0]       RUN_MAX     = RUN_W'(LOCK_COUNT);

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   div_edge;
    logic                   edge_q;
    logic [CNT_W-1:0]       cnt;
    logic [RUN_W-1:0]       run;
    logic signed [CNT_W:0]  diff;
    logic [CNT_W:0]         diff_abs;
    logic                   in_tol;
    logic                   cnt_clr;
    logic                   cnt_load;
    logic                   cnt_inc;
    logic                   meas;
    logic                   stall_set;
    logic                   run_clr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_divClk};
            hist_q <= sync_q[SYNC_STAGES-1];
            edge_q <= div_edge;
        end
    end

    // Both polarities count: each toggle of the divider ends a half-period.
    assign div_edge = sync_q[SYNC_STAGES-1] ^ hist_q;

    assign diff     = $signed({1'b0, cnt}) - EXP_S;
    assign diff_abs = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign in_tol   = (diff_abs <= TOL_U);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!i_ce) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (edge_q) state_nxt = MEASURE;
                MEASURE: if (!edge_q && cnt == CNT_TIMEOUT) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // An edge in the timeout cycle takes priority over the stall.
    always_comb begin
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        meas      = 1'b0;
        stall_set = 1'b0;
        if (!i_ce) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ARM, MEASURE: begin
                    if (edge_q) begin
                        cnt_load = 1'b1;
                        meas     = (state == MEASURE);
                    end else if (cnt == CNT_TIMEOUT) begin
                        stall_set = 1'b1;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: cnt_clr = 1'b1;
            endcase
        end
        run_clr = !i_ce || stall_set;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            run          <= '0;
            o_halfPeriod <= '0;
            o_valid      <= 1'b0;
            o_lock       <= 1'b0;
            o_stall      <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_load) begin
                cnt <= CNT_W'(1);
            end else if (cnt_inc && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            o_valid <= meas;
            if (meas) begin
                o_halfPeriod <= cnt;
            end

            if (run_clr) begin
                run    <= '0;
                o_lock <= 1'b0;
            end else if (meas) begin
                if (in_tol) begin
                    if (run < RUN_MAX) begin
                        run <= run + RUN_W'(1);
                    end
                    if (run >= RUN_MAX - RUN_W'(1)) begin
                        o_lock <= 1'b1;
                    end
                end else begin
                    run    <= '0;
                    o_lock <= 1'b0;
                end
            end

            if (i_clr) begin
                o_stall <= 1'b0;
            end else if (stall_set) begin
                o_stall <= 1'b1;
            end
        end
    end

`ifdef CLK_MON_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_cnt <= 8'd0;
        end else if (i_clr) begin
            err_cnt <= 8'd0;
        end else if (meas && !in_tol && !run_clr && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign o_errCnt = err_cnt;
`else
    assign o_errCnt = 8'd0;
`endif

endmodule

// File: doc/clk_period_monitor.md
# clk_period_monitor

Checker for the divided clocks produced by the team's clock dividers. It samples a slow, divider-generated toggle signal (for example the 1 kHz output) in the fast system clock domain and measures each half-period in system-clock cycles. It reports whether the signal is locked to the expected rate, has stalled, or is drifting. It sits beside a divider in lab designs as a self-check, and its results drive status LEDs.

## Interface
Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on i_divClk (≥2)
- CNT_W, 20, width of the measurement counter and o_halfPeriod
- EXP_HALF, 50000, expected half-period in i_clk cycles
- TOL, 16, allowed deviation (inclusive) from EXP_HALF
- LOCK_COUNT, 4, consecutive in-tolerance half-periods required to assert lock
- TIMEOUT, 200000, cycles without an edge before a stall is declared (< 2^CNT_W)

Ports:
- i_clk  in  1  system clock (100 MHz); all logic on the rising edge
- i_rst_n  in  1  reset; one clock, synchronous, active-low
- i_ce  in  1  monitor enable; low = idle
- i_clr  in  1  single-cycle pulse; clears o_errCnt and o_stall
- i_divClk  in  1  monitored slow signal, asynchronous to i_clk
- o_halfPeriod  out  CNT_W  last measured half-period
- o_valid  out  1  one-cycle pulse when o_halfPeriod updates
- o_lock  out  1  rate locked
- o_stall  out  1  sticky; no edge seen within TIMEOUT
- o_errCnt  out  8  saturating count of out-of-tolerance half-periods

## Operation
- i_divClk passes through SYNC_STAGES flops, then through one history flop. An edge pulse (`edge`) is the XOR of the last synchronizer stage and the history flop, so both rising and falling edges count.
- Counter `cnt` is CNT_W wide and saturates at 2^CNT_W−1.
- The FSM has three states: IDLE, ARM and MEASURE.
  - IDLE: `cnt`=0. Leave for ARM when i_ce=1.
  - ARM: on `edge`, set `cnt`←1 and go to MEASURE. Do not emit o_valid. Otherwise increment `cnt`.
  - MEASURE: on `edge`, set o_halfPeriod←`cnt`, pulse o_valid, set `cnt`←1, then run the tolerance check. Otherwise increment `cnt`.
- Tolerance check: a half-period is in tolerance when |`cnt`−EXP_HALF| ≤ TOL, computed at CNT_W+1 bits signed.
  - In tolerance: increment `run`, which saturates at LOCK_COUNT. o_lock←1 when `run` reaches LOCK_COUNT.
  - Out of tolerance: `run`←0, o_lock←0, o_errCnt increments and saturates at 255.
- Timeout applies in ARM or MEASURE. When `cnt`=TIMEOUT and there is no `edge`: o_stall←1, o_lock←0, `run`←0, `cnt`←0, and the FSM goes to ARM. o_stall stays set until i_clr.
- i_ce=0 in any state: go to IDLE, `cnt`←0, `run`←0, o_lock←0. o_halfPeriod, o_errCnt and o_stall hold their values.

## Timing
- Reset values: o_halfPeriod=0, o_valid=0, o_lock=0, o_stall=0, o_errCnt=0, FSM=IDLE, `cnt`=0, `run`=0, all synchronizer and history flops=0.
- Latency: i_divClk is first sampled high at posedge k. `edge` is high in the cycle after posedge k+SYNC_STAGES−1. o_valid, o_halfPeriod and o_lock update at posedge k+SYNC_STAGES+1.
- A divider that toggles every N cycles measures exactly N.
- o_valid is exactly one cycle wide.
- If `edge` and `cnt`=TIMEOUT occur in the same cycle, the edge wins and no stall is declared.
- If i_clr and an out-of-tolerance edge occur in the same cycle, i_clr wins: o_errCnt=0.
- If i_ce falls and `edge` occurs in the same cycle, i_ce wins: no o_valid.
- Reset mid-measurement: all state returns to reset values at the next edge. The first edge after reset only arms the FSM.

## Configuration
- CLK_MON_ERRCNT_EN defined: the o_errCnt counter and its i_clr clearing are implemented as described.
- CLK_MON_ERRCNT_EN undefined: o_errCnt is tied to 8'd0 and no counter flops are inferred. i_clr still clears o_stall. Lock and stall behaviour is unchanged.

## Test plan
- Toggle i_divClk every 50000 cycles with i_ce=1. Required: the first o_valid carries 50000, o_lock rises on the 4th o_valid, o_errCnt=0.
- Lock established, then one half-period of 50020 cycles. Required: o_valid carries 50020, o_lock drops that cycle, o_errCnt=1. Relock after 4 further 50000 half-periods.
- Lock established, then i_divClk held constant. Required: o_stall=1 and o_lock=0 exactly 200000 cycles after the last `edge`. o_stall clears only on i_clr; the first edge after the stall emits no o_valid.
- Edge coinciding with `cnt`=TIMEOUT, using a half-period of 200000. Required: o_valid with 200000, o_stall stays 0, o_errCnt increments.
- 300 out-of-tolerance half-periods of 40000. Required: o_errCnt saturates at 255. An i_clr pulse returns it to 0.
- i_rst_n low for one cycle mid-measurement, then i_ce dropped for 10 cycles. Required: all outputs at reset values, the FSM passes through ARM, and the first valid measurement follows the second edge.
